stack_datapath: RTL and testbench

- Parametrised successor to the single-width gameplay datapath for the stacking game.
- Owns the moving block (position, width, direction), the settled block below it, layer height, score and lives.
- On a drop it computes the overlap with the settled block, trims the moving block to that overlap, and updates score, lives and layer.
- Sits between the gameplay control FSM (start/tick/drop) and the VGA draw logic (positions/widths).

---
 rtl/stack_pkg.sv | 32 +++
 rtl/stack_datapath_if.sv | 33 +++
 rtl/stack_datapath_overlap_calc.sv | 24 ++
 rtl/stack_datapath.sv | 153 +++++++++++++++
 tb/tb_stack_datapath.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared constants for the stacking game: state encoding, move direction and
// default geometry used by the datapath, gameplay control and display logic.
package stack_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MOVE    = 3'd1;
    localparam logic [2:0] S_RESOLVE = 3'd2;
    localparam logic [2:0] S_UPDATE  = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_MOVE    = S_MOVE,
        ST_RESOLVE = S_RESOLVE,
        ST_UPDATE  = S_UPDATE,
        ST_OVER    = S_OVER
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int X_W_DEF      = 8;
    localparam int Y_W_DEF      = 7;
    localparam int SCREEN_W_DEF = 160;
    localparam int INIT_W_DEF   = 40;
    localparam int BLOCK_H_DEF  = 8;
    localparam int Y_BASE_DEF   = 112;
    localparam int Y_TOP_DEF    = 8;
    localparam int LIVES_DEF    = 10;
    localparam int SCORE_W_DEF  = 8;

endpackage

// File: rtl/stack_datapath_if.sv
// Control strobes from the gameplay FSM and block/score state towards the display.
interface stack_datapath_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int SCORE_W = 8
);
    logic               start;
    logic               tick;
    logic               drop;
    logic [X_W-1:0]     block_x;
    logic [X_W-1:0]     block_w;
    logic [X_W-1:0]     prev_x;
    logic [X_W-1:0]     prev_w;
    logic [Y_W-1:0]     layer_y;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic               busy;
    logic               result_valid;
    logic               hit;
    logic               game_over;

    modport master (
        output start, tick, drop,
        input  block_x, block_w, prev_x, prev_w, layer_y, score, lives,
               busy, result_valid, hit, game_over
    );

    modport slave (
        input  start, tick, drop,
        output block_x, block_w, prev_x, prev_w, layer_y, score, lives,
               busy, result_valid, hit, game_over
    );
endinterface

// File: rtl/stack_datapath_overlap_calc.sv
// Overlap of two horizontal spans [x, x+w); span ends are kept one bit wider so
// nothing wraps near the right edge of the playfield.
module overlap_calc #(
    parameter int X_W = 8
) (
    input  logic [X_W-1:0] a_x,
    input  logic [X_W-1:0] a_w,
    input  logic [X_W-1:0] b_x,
    input  logic [X_W-1:0] b_w,
    output logic [X_W-1:0] lo,
    output logic [X_W-1:0] ov
);
    logic [X_W:0] a_end;
    logic [X_W:0] b_end;
    logic [X_W:0] hi;

    always_comb begin
        a_end = {1'b0, a_x} + {1'b0, a_w};
        b_end = {1'b0, b_x} + {1'b0, b_w};
        lo    = (a_x > b_x) ? a_x : b_x;
        hi    = (a_end < b_end) ? a_end : b_end;
        ov    = (hi > {1'b0, lo}) ? X_W'(hi - {1'b0, lo}) : '0;
    end
endmodule

// File: rtl/stack_datapath.sv
// Stacking game datapath: moving/settled blocks, drop resolution, score, lives
// and layer height, sequenced by a small FSM.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// MOVE    | block bounces on tick, drop accepted
// RESOLVE | overlap of moving vs settled block registered
// UPDATE  | hit/miss applied, result_valid pulses next cycle
// OVER    | no lives left, waiting for start
module stack_datapath
    import stack_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int INIT_W   = INIT_W_DEF,
    parameter int BLOCK_H  = BLOCK_H_DEF,
    parameter int Y_BASE   = Y_BASE_DEF,
    parameter int Y_TOP    = Y_TOP_DEF,
    parameter int LIVES    = LIVES_DEF,
    parameter int SCORE_W  = SCORE_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    stack_datapath_if.slave  bus
);
    localparam logic [X_W-1:0]     INIT_W_V   = X_W'(INIT_W);
    localparam logic [X_W-1:0]     PREV_X0    = X_W'((SCREEN_W - INIT_W) / 2);
    localparam logic [X_W:0]       SCREEN_W_V = (X_W+1)'(SCREEN_W);
    localparam logic [X_W-1:0]     ONE_X      = X_W'(1);
    localparam logic [Y_W-1:0]     Y_BASE_V   = Y_W'(Y_BASE);
    localparam logic [Y_W:0]       Y_TOP_V    = (Y_W+1)'(Y_TOP);
    localparam logic [Y_W:0]       BLOCK_H_V  = (Y_W+1)'(BLOCK_H);
    localparam logic [3:0]         LIVES_V    = 4'(LIVES);
    localparam logic [SCORE_W-1:0] ONE_S      = SCORE_W'(1);

    state_t             state;
    logic               dir;
    logic [X_W-1:0]     block_x_q, block_w_q, prev_x_q, prev_w_q;
    logic [X_W-1:0]     lo_q, ov_q, lo_c, ov_c;
    logic [Y_W-1:0]     layer_y_q;
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         lives_q, lives_nx;
    logic               busy_q, rv_q, hit_q, over_q;
    logic [X_W:0]       right_end;
    logic [Y_W:0]       layer_dn;
    logic               scroll;

    overlap_calc #(.X_W(X_W)) u_overlap (
        .a_x (block_x_q),
        .a_w (block_w_q),
        .b_x (prev_x_q),
        .b_w (prev_w_q),
        .lo  (lo_c),
        .ov  (ov_c)
    );

    // layer_dn is one bit wider so a step below zero also triggers the scroll
    always_comb begin
        right_end = {1'b0, block_x_q} + {1'b0, block_w_q};
        layer_dn  = {1'b0, layer_y_q} - BLOCK_H_V;
        scroll    = layer_dn[Y_W] || (layer_dn < Y_TOP_V);
        lives_nx  = (ov_q == '0 && lives_q != 4'd0) ? lives_q - 4'd1 : lives_q;
    end

    always_ff @(posedge clk) begin
        if (reset || (bus.start && (state == ST_IDLE || state == ST_OVER))) begin
            state     <= reset ? ST_IDLE : ST_MOVE;
            dir       <= DIR_RIGHT;
            block_x_q <= '0;
            block_w_q <= INIT_W_V;
            prev_x_q  <= PREV_X0;
            prev_w_q  <= INIT_W_V;
            layer_y_q <= Y_BASE_V;
            score_q   <= '0;
            lives_q   <= LIVES_V;
            lo_q      <= '0;
            ov_q      <= '0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            hit_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (state)
                ST_MOVE: begin
                    if (bus.drop) begin
                        state  <= ST_RESOLVE;
                        busy_q <= 1'b1;
                    end else if (bus.tick) begin
                        if (dir == DIR_RIGHT) begin
                            if (right_end == SCREEN_W_V) begin
                                dir       <= DIR_LEFT;
                                block_x_q <= block_x_q - ONE_X;
                            end else begin
                                block_x_q <= block_x_q + ONE_X;
                            end
                        end else begin
                            if (block_x_q == '0) begin
                                dir       <= DIR_RIGHT;
                                block_x_q <= block_x_q + ONE_X;
                            end else begin
                                block_x_q <= block_x_q - ONE_X;
                            end
                        end
                    end
                end
                ST_RESOLVE: begin
                    lo_q  <= lo_c;
                    ov_q  <= ov_c;
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    busy_q    <= 1'b0;
                    rv_q      <= 1'b1;
                    block_x_q <= '0;
                    dir       <= DIR_RIGHT;
                    lives_q   <= lives_nx;
                    if (ov_q != '0) begin
                        hit_q     <= 1'b1;
                        prev_x_q  <= lo_q;
                        prev_w_q  <= ov_q;
                        block_w_q <= ov_q;
                        layer_y_q <= scroll ? Y_BASE_V : layer_dn[Y_W-1:0];
                        if (score_q != '1)
                            score_q <= score_q + ONE_S;
                    end else begin
                        hit_q <= 1'b0;
                    end
                    if (lives_nx == 4'd0) begin
                        state  <= ST_OVER;
                        over_q <= 1'b1;
                    end else begin
                        state <= ST_MOVE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.block_x      = block_x_q;
    assign bus.block_w      = block_w_q;
    assign bus.prev_x       = prev_x_q;
    assign bus.prev_w       = prev_w_q;
    assign bus.layer_y      = layer_y_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;
    assign bus.hit          = hit_q;
    assign bus.game_over    = over_q;
endmodule

// File: tb/tb_stack_datapath.sv
// Directed bench for stack_datapath: vector table for tick/drop outcomes plus
// hand sequences for bounce, drop/tick collision, scroll, game over and reset.
module tb_stack_datapath;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stack_datapath_if #(.X_W(8), .Y_W(7), .SCORE_W(8)) bus ();

    stack_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int ticks;
        bit drp;
        int bx, bw, px, pw, ly, sc, lv, ht;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int bx, int bw, int px, int pw,
                             int ly, int sc, int lv, int ht);
        chk({tag, ".block_x"}, int'(bus.block_x), bx);
        chk({tag, ".block_w"}, int'(bus.block_w), bw);
        chk({tag, ".prev_x"},  int'(bus.prev_x),  px);
        chk({tag, ".prev_w"},  int'(bus.prev_w),  pw);
        chk({tag, ".layer_y"}, int'(bus.layer_y), ly);
        chk({tag, ".score"},   int'(bus.score),   sc);
        chk({tag, ".lives"},   int'(bus.lives),   lv);
        chk({tag, ".hit"},     int'(bus.hit),     ht);
    endtask

    task automatic do_ticks(int n);
        if (n > 0) begin
            @(negedge clk) bus.tick = 1'b1;
            repeat (n) @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    // edges counts posedges from the one that samples drop; 8 means no result
    task automatic do_drop(output int edges);
        @(negedge clk) bus.drop = 1'b1;
        @(negedge clk) bus.drop = 1'b0;
        edges = 1;
        while (!bus.result_valid && edges < 8) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    initial begin
        int e;
        int rv_cnt;
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        bus.drop  = 1'b0;
        reset     = 1'b1;

        //            ticks drp  bx  bw  px  pw  ly   sc lv ht
        vecs[0] = '{10,  1'b0, 10, 40, 60, 40, 112, 0, 10, 0};
        vecs[1] = '{60,  1'b1,  0, 30, 70, 30, 104, 1, 10, 1};
        vecs[2] = '{40,  1'b1,  0, 30, 70, 30, 104, 1,  9, 0};
        vecs[3] = '{99,  1'b1,  0,  1, 99,  1,  96, 2,  9, 1};
        vecs[4] = '{99,  1'b1,  0,  1, 99,  1,  88, 3,  9, 1};
        vecs[5] = '{100, 1'b1,  0,  1, 99,  1,  88, 3,  8, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all("reset", 0, 40, 60, 40, 112, 0, 10, 0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.game_over", int'(bus.game_over), 0);
        chk("reset.result_valid", int'(bus.result_valid), 0);
        do_ticks(3);
        @(negedge clk);
        chk("idle_tick_ignored", int'(bus.block_x), 0);

        pulse_start();
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_ticks(vecs[i].ticks);
            if (vecs[i].drp) begin
                do_drop(e);
                chk({tag, ".latency"}, e, 3);
                chk({tag, ".busy"}, int'(bus.busy), 0);
            end else begin
                @(negedge clk);
            end
            check_all(tag, vecs[i].bx, vecs[i].bw, vecs[i].px, vecs[i].pw,
                      vecs[i].ly, vecs[i].sc, vecs[i].lv, vecs[i].ht);
        end

        pulse_start();
        chk("start_ignored_in_move", int'(bus.score), 3);

        // reset asserted while the drop is being resolved
        @(negedge clk) bus.drop = 1'b1;
        @(negedge clk) bus.drop = 1'b0;
        chk("resolve.busy", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        rv_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            rv_cnt += int'(bus.result_valid);
        end
        check_all("midreset", 0, 40, 60, 40, 112, 0, 10, 0);
        chk("midreset.no_result", rv_cnt, 0);
        chk("midreset.busy", int'(bus.busy), 0);

        pulse_start();
        do_ticks(120);
        @(negedge clk);
        chk("bounce.right_edge", int'(bus.block_x), 120);
        do_ticks(1);
        chk("bounce.turn_left", int'(bus.block_x), 119);
        do_ticks(119);
        chk("bounce.at_zero", int'(bus.block_x), 0);
        do_ticks(1);
        chk("bounce.turn_right", int'(bus.block_x), 1);
        do_ticks(29);
        chk("move.at_30", int'(bus.block_x), 30);

        // drop with a simultaneous tick, drop then held through busy
        rv_cnt = 0;
        @(negedge clk) begin bus.drop = 1'b1; bus.tick = 1'b1; end
        @(negedge clk) bus.tick = 1'b0;
        chk("droptick.block_x", int'(bus.block_x), 30);
        chk("droptick.busy", int'(bus.busy), 1);
        rv_cnt += int'(bus.result_valid);
        @(negedge clk);
        rv_cnt += int'(bus.result_valid);
        @(negedge clk) bus.drop = 1'b0;
        rv_cnt += int'(bus.result_valid);
        repeat (6) begin
            @(negedge clk);
            rv_cnt += int'(bus.result_valid);
        end
        chk("droptick.one_result", rv_cnt, 1);
        check_all("droptick", 0, 10, 60, 10, 104, 1, 10, 1);

        for (int i = 0; i < 12; i++) begin
            do_ticks(60);
            do_drop(e);
        end
        check_all("stack13", 0, 10, 60, 10, 8, 13, 10, 1);
        do_ticks(60);
        do_drop(e);
        check_all("scroll", 0, 10, 60, 10, 112, 14, 10, 1);

        for (int i = 0; i < 9; i++) do_drop(e);
        chk("miss9.lives", int'(bus.lives), 1);
        chk("miss9.game_over", int'(bus.game_over), 0);
        do_drop(e);
        chk("miss10.lives", int'(bus.lives), 0);
        chk("miss10.game_over", int'(bus.game_over), 1);
        chk("miss10.hit", int'(bus.hit), 0);
        do_drop(e);
        chk("over.drop_ignored", e, 8);
        pulse_start();
        check_all("restart", 0, 40, 60, 40, 112, 0, 10, 0);
        chk("restart.game_over", int'(bus.game_over), 0);
        do_ticks(5);
        chk("restart.moving", int'(bus.block_x), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
